// File: rtl/cache_sweep_requester.sv
// cache_sweep_requester
// Initiator for the direct-mapped cache access interface. It sweeps the
// address range [start_addr, end_addr) modulo 2^ADDR_W and presents one address
// at a time. It waits for hit or miss, captures the returned word, and counts
// hits and misses. When start_addr == end_addr the sweep covers the whole
// address space.
//
// Optional feature: define CACHE_REQ_TIMEOUT_EN to bound each WAIT phase to
// TIMEOUT_CYCLES silent cycles. When the bound is hit, timeout_err is raised
// and the sweep ends. Without the macro timeout_err is constant 0 and WAIT
// holds until a response arrives.

module cache_sweep_requester #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              hit,
    input  logic              miss,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] last_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [CNT_W-1:0]  hit_count_q, hit_count_d;
    logic [CNT_W-1:0]  miss_count_q, miss_count_d;
    logic [ADDR_W-1:0] next_addr;
    logic              resp;

`ifdef CACHE_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    // The address increments modulo 2^ADDR_W, so a sweep can wrap past the top of the address space.
    assign next_addr = address_q + ADDR_W'(1);
    assign resp      = hit | miss;

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        end_d        = end_q;
        last_data_d  = last_data_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`ifdef CACHE_REQ_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    address_d    = start_addr;
                    end_d        = end_addr;
                    hit_count_d  = '0;
                    miss_count_d = '0;
`ifdef CACHE_REQ_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    state_d      = S_ISSUE;
                end
            end
            // Responses are ignored here. A late response to the previous
            // address must never be credited to the new one.
            S_ISSUE: begin
`ifdef CACHE_REQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (resp) begin
                    if (miss) begin
                        miss_count_d = miss_count_q + CNT_W'(1);
                    end else begin
                        hit_count_d = hit_count_q + CNT_W'(1);
                    end
                    last_data_d = data_in;
                    if (next_addr == end_q) begin
                        state_d = S_DONE;
                    end else begin
                        address_d = next_addr;
                        state_d   = S_ISSUE;
                    end
                end
`ifdef CACHE_REQ_TIMEOUT_EN
                // A response on the limiting cycle takes the branch above and is counted normally.
                else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any sweep in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            address_q    <= '0;
            end_q        <= '0;
            last_data_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            end_q        <= end_d;
            last_data_q  <= last_data_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`ifdef CACHE_REQ_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign address    = address_q;
    assign last_data  = last_data_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);

`ifdef CACHE_REQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    // This build never times out. The expression is always false; the timeout limit only matters in the timeout build.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule
